// File: rtl/dac_spi_serializer.sv
// Serializes a 12-bit sample behind a 4-bit command nibble into a 16-bit SPI (mode 0) DAC frame.
// Optional macro DAC_LDAC_EN adds an LDAC_n strobe phase after chip select is released.
module dac_spi_serializer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [3:0]  CTRL_BITS = 4'b0011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [11:0] Din,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        SCLK,
    output logic        SDO,
    output logic        CS_n
`ifdef DAC_LDAC_EN
    ,
    output logic        LDAC_n
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
`ifdef DAC_LDAC_EN
        ,
        LDAC
`endif
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_reg;
    logic [7:0]  div_reg;
    logic [4:0]  bit_reg;
    // Bits still to be sent after the one currently on SDO, MSB first.
    logic [14:0] shreg_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        sclk_reg;
    logic        sdo_reg;
    logic        cs_n_reg;
`ifdef DAC_LDAC_EN
    logic        ldac_n_reg;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg  <= IDLE;
            div_reg    <= '0;
            bit_reg    <= '0;
            shreg_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sclk_reg   <= 1'b0;
            sdo_reg    <= 1'b0;
            cs_n_reg   <= 1'b1;
`ifdef DAC_LDAC_EN
            ldac_n_reg <= 1'b1;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        shreg_reg <= {CTRL_BITS[2:0], Din};
                        sdo_reg   <= CTRL_BITS[3];
                        cs_n_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= SHIFT;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg <= '0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                            bit_reg  <= bit_reg + 5'd1;
                        end else begin
                            sclk_reg <= 1'b0;
                            // The falling edge after the 16th rise closes the data phase.
                            if (bit_reg == 5'd16) begin
                                sdo_reg   <= 1'b0;
                                bit_reg   <= '0;
                                state_reg <= HOLD;
                            end else begin
                                sdo_reg   <= shreg_reg[14];
                                shreg_reg <= {shreg_reg[13:0], 1'b0};
                            end
                        end
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg  <= '0;
                        bit_reg  <= '0;
                        cs_n_reg <= 1'b1;
`ifdef DAC_LDAC_EN
                        state_reg <= LDAC;
`else
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
`endif
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
`ifdef DAC_LDAC_EN
                LDAC: begin
                    // First LDAC cycle is the CS_n-high gap; the strobe follows it.
                    if (ldac_n_reg) begin
                        ldac_n_reg <= 1'b0;
                        div_reg    <= '0;
                    end else if (div_reg == DIV_LAST) begin
                        ldac_n_reg <= 1'b1;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        div_reg    <= '0;
                        state_reg  <= IDLE;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign SCLK = sclk_reg;
    assign SDO  = sdo_reg;
    assign CS_n = cs_n_reg;
`ifdef DAC_LDAC_EN
    assign LDAC_n = ldac_n_reg;
`endif

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed self-checking bench for dac_spi_serializer: one DUT at CLK_DIV=4, one at CLK_DIV=1.
// Build with DAC_LDAC_EN defined to exercise the LDAC_n variant.
module tb_dac_spi_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] din_a, din_b;
    logic        start_a, start_b;
    logic        busy_a, done_a, sclk_a, sdo_a, cs_a;
    logic        busy_b, done_b, sclk_b, sdo_b, cs_b;
`ifdef DAC_LDAC_EN
    logic        ldac_a, ldac_b;
    localparam int BUSY_A = 141, DONE_A = 142, BUSY_B = 36, DONE_B = 37;
`else
    localparam int BUSY_A = 136, DONE_A = 137, BUSY_B = 34, DONE_B = 35;
`endif

    always #5 clk = ~clk;

    dac_spi_serializer #(.CLK_DIV(4), .CTRL_BITS(4'b0011)) dut_a (
        .Clock(clk), .Reset(rst_n), .Din(din_a), .Start(start_a),
        .Busy(busy_a), .Done(done_a), .SCLK(sclk_a), .SDO(sdo_a),
`ifdef DAC_LDAC_EN
        .LDAC_n(ldac_a),
`endif
        .CS_n(cs_a)
    );

    dac_spi_serializer #(.CLK_DIV(1), .CTRL_BITS(4'b0011)) dut_b (
        .Clock(clk), .Reset(rst_n), .Din(din_b), .Start(start_b),
        .Busy(busy_b), .Done(done_b), .SCLK(sclk_b), .SDO(sdo_b),
`ifdef DAC_LDAC_EN
        .LDAC_n(ldac_b),
`endif
        .CS_n(cs_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int busy_cnt_a, rise_cnt_a, done_cnt_a, done_off_a, first_rise_a, last_rise_a, ldac_cnt_a, ldac_bad_a;
    int busy_cnt_b, rise_cnt_b, done_cnt_b, done_off_b, first_rise_b, last_rise_b, ldac_cnt_b, ldac_bad_b;
    logic [15:0] cap_a, cap_b;
    logic prev_sclk_a, prev_sclk_b;
    int frames, done_before;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        cyc = 0;
        busy_cnt_a = 0; rise_cnt_a = 0; done_cnt_a = 0; done_off_a = 0;
        first_rise_a = -1; last_rise_a = -1; ldac_cnt_a = 0; ldac_bad_a = 0; cap_a = '0;
        busy_cnt_b = 0; rise_cnt_b = 0; done_cnt_b = 0; done_off_b = 0;
        first_rise_b = -1; last_rise_b = -1; ldac_cnt_b = 0; ldac_bad_b = 0; cap_b = '0;
    endtask

    // One clock: outputs sampled on the falling Clock edge, SPI bits captured on SCLK rises.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (busy_a === 1'b1) busy_cnt_a++;
        if (sclk_a === 1'b1 && prev_sclk_a === 1'b0) begin
            rise_cnt_a++;
            cap_a = {cap_a[14:0], sdo_a};
            if (first_rise_a < 0) first_rise_a = cyc;
            last_rise_a = cyc;
        end
        prev_sclk_a = sclk_a;
        if (done_a === 1'b1) begin done_cnt_a++; done_off_a = cyc; end
        if (busy_b === 1'b1) busy_cnt_b++;
        if (sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
            rise_cnt_b++;
            cap_b = {cap_b[14:0], sdo_b};
            if (first_rise_b < 0) first_rise_b = cyc;
            last_rise_b = cyc;
        end
        prev_sclk_b = sclk_b;
        if (done_b === 1'b1) begin done_cnt_b++; done_off_b = cyc; end
`ifdef DAC_LDAC_EN
        if (ldac_a === 1'b0) begin ldac_cnt_a++; if (cs_a !== 1'b1) ldac_bad_a++; end
        if (ldac_b === 1'b0) begin ldac_cnt_b++; if (cs_b !== 1'b1) ldac_bad_b++; end
`endif
    endtask

    task automatic frame_a(input logic [11:0] d);
        clr_mon();
        din_a = d; start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (done_cnt_a == 0 && cyc < 400) step();
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; din_a = '0; din_b = '0;
        prev_sclk_a = 1'b0; prev_sclk_b = 1'b0;
        clr_mon();

        // Reset held 3 cycles, then idle with no Start
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_a", {cs_a, sclk_a, sdo_a, busy_a, done_a}, 5'b10000);
            check("idle_b", {cs_b, sclk_b, sdo_b, busy_b, done_b}, 5'b10000);
        end

        // CLK_DIV=4 single frame
        frame_a(12'hA5C);
        check("a5c_done_seen", done_cnt_a, 1);
        check("a5c_frame", cap_a, 16'h3A5C);
        check("a5c_busy_len", busy_cnt_a, BUSY_A);
        check("a5c_done_off", done_off_a, DONE_A);
        check("a5c_rises", rise_cnt_a, 16);
        check("a5c_first_rise", first_rise_a, 9);
        check("a5c_rise_span", last_rise_a - first_rise_a, 120);
`ifdef DAC_LDAC_EN
        check("a5c_ldac_len", ldac_cnt_a, 4);
        check("a5c_ldac_cs", ldac_bad_a, 0);
`endif

        // Start during a busy frame with new Din is ignored
        clr_mon();
        din_a = 12'h5A3; start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (done_cnt_a == 0 && cyc < 400) begin
            if (cyc == 19) begin start_a = 1'b1; din_a = 12'hFFF; end
            else start_a = 1'b0;
            step();
        end
        start_a = 1'b0;
        repeat (10) step();
        check("ign_frame", cap_a, 16'h35A3);
        check("ign_done_cnt", done_cnt_a, 1);
        check("ign_busy_len", busy_cnt_a, BUSY_A);
        check("ign_idle_after", {cs_a, busy_a}, 2'b10);

        // Start held high: back-to-back frames
        clr_mon();
        frames = 0;
        din_a = 12'h001; start_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done_a === 1'b1) begin
                check("b2b_frame", cap_a, 16'h3001);
                check("b2b_gap_cs", cs_a, 1'b1);
                cap_a = '0;
                frames++;
                step();
                i++;
                check("b2b_reaccept", {busy_a, cs_a}, 2'b10);
            end
        end
        check("b2b_frames", frames, 2);
        start_a = 1'b0;
        done_before = done_cnt_a;
        for (int i = 0; i < 400 && done_cnt_a == done_before; i++) step();
        check("b2b_drain", done_cnt_a, done_before + 1);
        check("b2b_last_frame", cap_a, 16'h3001);

        // Reset at the 8th SCLK rise aborts the frame
        clr_mon();
        din_a = 12'h7E1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (rise_cnt_a < 8 && cyc < 400) step();
        check("rst_at_rise8", rise_cnt_a, 8);
        rst_n = 1'b0;
        step();
        check("rst_abort", {cs_a, sclk_a, sdo_a, busy_a, done_a}, 5'b10000);
        rst_n = 1'b1;
        repeat (6) step();
        check("rst_no_done", done_cnt_a, 0);
        frame_a(12'h123);
        check("rst_clean_frame", cap_a, 16'h3123);
        check("rst_clean_rises", rise_cnt_a, 16);
        check("rst_clean_busy", busy_cnt_a, BUSY_A);

        // CLK_DIV=1 frame
        clr_mon();
        din_b = 12'h800; start_b = 1'b1;
        step();
        start_b = 1'b0;
        while (done_cnt_b == 0 && cyc < 200) step();
        check("d1_done_seen", done_cnt_b, 1);
        check("d1_frame", cap_b, 16'h3800);
        check("d1_busy_len", busy_cnt_b, BUSY_B);
        check("d1_done_off", done_off_b, DONE_B);
        check("d1_rises", rise_cnt_b, 16);
        check("d1_first_rise", first_rise_b, 3);
        check("d1_rise_span", last_rise_b - first_rise_b, 30);
`ifdef DAC_LDAC_EN
        check("d1_ldac_len", ldac_cnt_b, 1);
        check("d1_ldac_cs", ldac_bad_b, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
